// File: rtl/basamak_tarayici.sv
// Multi-cycle bit-position finder: captures a W-bit word and scans STEP bits per clock,
// reporting the lowest (mod=0) or highest (mod=1) set bit index, or W for an all-zero word.
module basamak_tarayici #(
    parameter int W    = 16,
    parameter int STEP = 4,
    localparam int G   = W / STEP,
    localparam int BW  = $clog2(W + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic          mod,
    input  logic [W-1:0]  sayi,
    output logic          hazir,
    output logic          bitti,
    output logic [BW-1:0] basamak,
    output logic          sifir
);
    localparam int GW = (G > 1) ? $clog2(G) : 1;

    typedef enum logic {BOS = 1'b0, TARA = 1'b1} state_t;

    state_t        state_q, state_d;
    logic [GW-1:0] g_q, g_d;
    logic [W-1:0]  word_q, word_d;
    logic          mod_q, mod_d;
    logic [BW-1:0] basamak_q, basamak_d;
    logic          sifir_q, sifir_d;
    logic          bitti_q, bitti_d;

    logic [BW-1:0]   g_off, base, idx;
    logic [W-1:0]    shifted;
    logic [STEP-1:0] grp;
    logic            hit, last;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= BOS;
            g_q       <= '0;
            word_q    <= '0;
            mod_q     <= 1'b0;
            basamak_q <= '0;
            sifir_q   <= 1'b0;
            bitti_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            g_q       <= g_d;
            word_q    <= word_d;
            mod_q     <= mod_d;
            basamak_q <= basamak_d;
            sifir_q   <= sifir_d;
            bitti_q   <= bitti_d;
        end
    end

    // Group base: LSB end upward for mod=0, MSB end downward for mod=1.
    always_comb begin
        g_off   = BW'(g_q) * BW'(STEP);
        base    = mod_q ? (BW'(W - STEP) - g_off) : g_off;
        shifted = word_q >> base;
        grp     = shifted[STEP-1:0];
        hit     = |grp;
        last    = (g_q == GW'(G - 1));
        idx     = '0;
        if (mod_q) begin
            for (int i = 0; i < STEP; i++)
                if (grp[i]) idx = BW'(i);
        end else begin
            for (int i = STEP - 1; i >= 0; i--)
                if (grp[i]) idx = BW'(i);
        end
    end

    always_comb begin
        state_d   = state_q;
        g_d       = g_q;
        word_d    = word_q;
        mod_d     = mod_q;
        basamak_d = basamak_q;
        sifir_d   = sifir_q;
        bitti_d   = 1'b0;
        case (state_q)
            BOS: begin
                if (start) begin
                    word_d  = sayi;
                    mod_d   = mod;
                    g_d     = '0;
                    sifir_d = 1'b0;
                    state_d = TARA;
                end
            end
            TARA: begin
                if (hit) begin
                    basamak_d = base + idx;
                    sifir_d   = 1'b0;
                    bitti_d   = 1'b1;
                    state_d   = BOS;
                end else if (last) begin
                    basamak_d = BW'(W);
                    sifir_d   = 1'b1;
                    bitti_d   = 1'b1;
                    state_d   = BOS;
                end else begin
                    g_d = g_q + 1'b1;
                end
            end
            default: state_d = BOS;
        endcase
    end

    assign hazir   = (state_q == BOS);
    assign bitti   = bitti_q;
    assign basamak = basamak_q;
    assign sifir   = sifir_q;
endmodule
